guess_ctrl: RTL



---
 rtl/guess_pkg.sv | 37 +++
 rtl/lfsr8.sv | 30 +++
 rtl/guess_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/guess_pkg.sv
// rtl/guess_pkg.sv - shared types, status field layout and LFSR step for the guessing-game controller
package guess_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARM        = 3'd1,
        ST_WAIT_GUESS = 3'd2,
        ST_COMPARE    = 3'd3,
        ST_WIN        = 3'd4,
        ST_LOSE       = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_HIGH = 2'd1,
        RES_EQ   = 2'd2,
        RES_LOW  = 2'd3
    } result_t;

    // Comparator status word layout: {pad[1:0], mode[1:0], result[1:0]}
    localparam int ST_RES_LSB  = 0;
    localparam int ST_MODE_LSB = 2;
    localparam int ST_PAD_LSB  = 4;

    // Fibonacci step for x^8+x^6+x^5+x^4+1; a nonzero state never maps to zero
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // A status word is usable only with zero padding, the round's mode echoed back and a real result
    function automatic logic status_ok(input logic [5:0] st, input logic [1:0] round_mode);
        return (st[ST_PAD_LSB +: 2] == 2'b00)
            && (st[ST_MODE_LSB +: 2] == round_mode)
            && (st[ST_RES_LSB +: 2] != RES_NONE);
    endfunction

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - free-running 8-bit LFSR used as the round target source
module lfsr8
    import guess_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_d;
    logic [7:0] q_q;

    // Next LFSR state, advanced every cycle
    always_comb begin
        q_d = lfsr_next(q_q);
    end

    // State register, reloaded with the seed on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/guess_ctrl.sv
// rtl/guess_ctrl.sv - round controller: target generation, guess forwarding and status decode
module guess_ctrl
    import guess_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         MAX_TRIES = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       guess_valid,
    input  logic [7:0] guess_data,
    output logic       guess_ready,
    input  logic [5:0] status,
    output logic [7:0] rand_val,
    output logic [2:0] count,
    output logic [7:0] cmp_data,
    output logic       hint_hi,
    output logic       hint_lo,
    output logic       win,
    output logic       lose,
    output logic       err,
    output logic       busy
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_TRIES);

    logic [7:0] lfsr_q;

    state_t     state_d, state_q;
    logic [1:0] mode_d, mode_q;
    logic [7:0] rand_d, rand_q;
    logic [2:0] count_d, count_q;
    logic [7:0] cmp_data_d, cmp_data_q;
    logic       hint_hi_d, hint_hi_q;
    logic       hint_lo_d, hint_lo_q;
    logic       win_d, win_q;
    logic       lose_d, lose_q;
    logic       err_d, err_q;
    logic       guess_ready_d, guess_ready_q;
    logic       busy_d, busy_q;
    result_t    res;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    assign res = result_t'(status[ST_RES_LSB +: 2]);

    // Round FSM next-state and next-output computation
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        rand_d     = rand_q;
        count_d    = count_q;
        cmp_data_d = cmp_data_q;
        hint_hi_d  = hint_hi_q;
        hint_lo_d  = hint_lo_q;
        win_d      = win_q;
        lose_d     = lose_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    state_d   = ST_ARM;
                    mode_d    = mode;
                    count_d   = 3'd0;
                    hint_hi_d = 1'b0;
                    hint_lo_d = 1'b0;
                    win_d     = 1'b0;
                    lose_d    = 1'b0;
                end
            end
            ST_ARM: begin
                rand_d  = lfsr_q;
                state_d = ST_WAIT_GUESS;
            end
            ST_WAIT_GUESS: begin
                if (guess_valid && guess_ready_q) begin
                    cmp_data_d = guess_data;
                    state_d    = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (!status_ok(status, mode_q)) begin
                    // Malformed word: flag it and let the player retry without a penalty
                    err_d   = 1'b1;
                    state_d = ST_WAIT_GUESS;
                end else if (res == RES_EQ) begin
                    win_d     = 1'b1;
                    hint_hi_d = 1'b0;
                    hint_lo_d = 1'b0;
                    state_d   = ST_WIN;
                end else begin
                    hint_hi_d = (res == RES_HIGH);
                    hint_lo_d = (res == RES_LOW);
                    count_d   = count_q + 3'd1;
                    if (count_d == MAX_CNT) begin
                        lose_d  = 1'b1;
                        state_d = ST_LOSE;
                    end else begin
                        state_d = ST_WAIT_GUESS;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake and activity flags follow the next state so they are registered with it
        guess_ready_d = (state_d == ST_WAIT_GUESS);
        busy_d        = (state_d == ST_ARM) || (state_d == ST_WAIT_GUESS) || (state_d == ST_COMPARE);
    end

    // Round state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mode_q        <= 2'd0;
            rand_q        <= 8'd0;
            count_q       <= 3'd0;
            cmp_data_q    <= 8'd0;
            hint_hi_q     <= 1'b0;
            hint_lo_q     <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            err_q         <= 1'b0;
            guess_ready_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            rand_q        <= rand_d;
            count_q       <= count_d;
            cmp_data_q    <= cmp_data_d;
            hint_hi_q     <= hint_hi_d;
            hint_lo_q     <= hint_lo_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
            err_q         <= err_d;
            guess_ready_q <= guess_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign rand_val    = rand_q;
    assign count       = count_q;
    assign cmp_data    = cmp_data_q;
    assign hint_hi     = hint_hi_q;
    assign hint_lo     = hint_lo_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign err         = err_q;
    assign guess_ready = guess_ready_q;
    assign busy        = busy_q;

endmodule
